// File: rtl/compare_search8.sv
// Binary-search controller driving comparator B: converges on the unknown A value
// from one-hot comparator results, reporting the match, probe count and consistency errors.
module compare_search8 #(
  parameter int unsigned CMP_LAT = 1
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       Start,
  input  logic [2:0] R,
  output logic [7:0] Guess,
  output logic       Busy,
  output logic       Done,
  output logic       Err,
  output logic [7:0] Found,
  output logic [3:0] Probes
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam logic [3:0] LAT = CMP_LAT[3:0];
  // A combinational comparator skips SETTLE entirely: one edge per probe.
  localparam logic [2:0] PROBE_ENTRY = (CMP_LAT == 0) ? S_SAMPLE : S_SETTLE;

  logic [2:0] state;
  logic [3:0] cnt;
  logic [7:0] lo, hi;

  logic [7:0] lo_up, hi_dn, mid_up, mid_dn;
  logic [8:0] sum_up, sum_dn;
  logic       up_bad, dn_bad;
  logic [3:0] probes_inc;

  always_comb begin
    lo_up      = Guess + 8'd1;
    hi_dn      = Guess - 8'd1;
    sum_up     = {1'b0, lo_up} + {1'b0, hi};
    sum_dn     = {1'b0, lo} + {1'b0, hi_dn};
    mid_up     = sum_up[8:1];
    mid_dn     = sum_dn[8:1];
    // Exhaustion is caught before lo/hi can wrap past the 8-bit range.
    up_bad     = (Guess == 8'hFF) || (lo_up > hi);
    dn_bad     = (Guess == 8'h00) || (lo > hi_dn);
    probes_inc = (Probes == 4'hF) ? Probes : Probes + 4'd1;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      lo     <= '0;
      hi     <= '1;
      Guess  <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Err    <= 1'b0;
      Found  <= '0;
      Probes <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (Start) begin
            lo     <= '0;
            hi     <= '1;
            Guess  <= 8'd127;
            Probes <= '0;
            Done   <= 1'b0;
            Err    <= 1'b0;
            Busy   <= 1'b1;
            cnt    <= LAT;
            state  <= PROBE_ENTRY;
          end
        end
        S_SETTLE: begin
          if (cnt <= 4'd1) begin
            cnt   <= '0;
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_SAMPLE: begin
          Probes <= probes_inc;
          case (R)
            3'b010: begin
              Found <= Guess;
              Done  <= 1'b1;
              Busy  <= 1'b0;
              state <= S_DONE;
            end
            3'b100: begin
              if (up_bad) begin
                Err   <= 1'b1;
                Busy  <= 1'b0;
                state <= S_ERROR;
              end else begin
                lo    <= lo_up;
                Guess <= mid_up;
                cnt   <= LAT;
                state <= PROBE_ENTRY;
              end
            end
            3'b001: begin
              if (dn_bad) begin
                Err   <= 1'b1;
                Busy  <= 1'b0;
                state <= S_ERROR;
              end else begin
                hi    <= hi_dn;
                Guess <= mid_dn;
                cnt   <= LAT;
                state <= PROBE_ENTRY;
              end
            end
            default: begin
              Err   <= 1'b1;
              Busy  <= 1'b0;
              state <= S_ERROR;
            end
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compare_search8.sv
// Bench for compare_search8: a registered comparator model (CMP_LAT=1) and a
// combinational one (CMP_LAT=0), table-driven searches plus handshake/error corners.
module tb_compare_search8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start0;
  logic [7:0] a_val;
  logic [2:0] r, r0, r_reg, r_force;
  logic       force_en;
  logic [7:0] guess, found, guess0, found0;
  logic       busy, done, err, busy0, done0, err0;
  logic [3:0] probes, probes0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] seq[$];

  always #5 clk = ~clk;

  compare_search8 #(.CMP_LAT(1)) dut (
    .Clk(clk), .nReset(rst_n), .Start(start), .R(r),
    .Guess(guess), .Busy(busy), .Done(done), .Err(err),
    .Found(found), .Probes(probes)
  );

  compare_search8 #(.CMP_LAT(0)) dut0 (
    .Clk(clk), .nReset(rst_n), .Start(start0), .R(r0),
    .Guess(guess0), .Busy(busy0), .Done(done0), .Err(err0),
    .Found(found0), .Probes(probes0)
  );

  function automatic logic [2:0] cmp(input logic [7:0] a, input logic [7:0] b);
    if (a > b)       return 3'b100;
    else if (a == b) return 3'b010;
    else             return 3'b001;
  endfunction

  always_ff @(posedge clk) r_reg <= cmp(a_val, guess);
  assign r  = force_en ? r_force : r_reg;
  assign r0 = cmp(a_val, guess0);

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Accept a search at edge s, then count edges until Done or Err rises.
  task automatic run(input logic [7:0] a, output int cycles);
    a_val = a;
    seq.delete();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("accept_guess", guess, 127);
    check("accept_busy", busy, 1);
    check("accept_done_clr", done, 0);
    check("accept_err_clr", err, 0);
    seq.push_back(guess);
    cycles = 0;
    while (cycles < 60) begin
      @(posedge clk); #1;
      cycles++;
      if (guess != seq[$]) seq.push_back(guess);
      if (done || err) break;
    end
    if (!(done || err)) check("search_timeout", cycles, -1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] exp_found;
    int         exp_probes;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] e255[9] = '{8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254, 8'd255};
  logic [7:0] e0[8]   = '{8'd127, 8'd63, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1, 8'd0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    vecs[0] = '{8'd127, 8'd127, 1};
    vecs[1] = '{8'd255, 8'd255, 9};
    vecs[2] = '{8'd200, 8'd200, 8};
    vecs[3] = '{8'd0,   8'd0,   8};
    vecs[4] = '{8'd63,  8'd63,  2};
    vecs[5] = '{8'd191, 8'd191, 2};
    vecs[6] = '{8'd128, 8'd128, 8};
    vecs[7] = '{8'd1,   8'd1,   7};

    force_en = 1'b0; r_force = 3'b000;
    start = 1'b0; start0 = 1'b0; a_val = 8'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_guess", guess, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_probes", probes, 0);
    @(negedge clk) rst_n = 1'b1;

    // Asynchronous reset in the middle of a search.
    a_val = 8'd0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (probes != 4'd3 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mid_probes3", probes, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_guess", guess, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_err", err, 0);
    check("async_found", found, 0);
    check("async_probes", probes, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end

    // Table-driven searches; each accepted start is a restart from DONE.
    foreach (vecs[i]) begin
      run(vecs[i].a, cyc);
      check("found", found, vecs[i].exp_found);
      check("probes", probes, vecs[i].exp_probes);
      check("latency", cyc, 2 * vecs[i].exp_probes);
      check("done", done, 1);
      check("err", err, 0);
      check("busy", busy, 0);
      if (vecs[i].a == 8'd255) begin
        check("seq255_len", seq.size(), 9);
        for (int k = 0; k < 9 && k < seq.size(); k++) check("seq255", seq[k], e255[k]);
      end
      if (vecs[i].a == 8'd0) begin
        check("seq0_len", seq.size(), 8);
        for (int k = 0; k < 8 && k < seq.size(); k++) check("seq0", seq[k], e0[k]);
      end
    end

    // Start pulsed while busy is ignored.
    a_val = 8'd255;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (cyc < 60) begin
      if (cyc == 4) begin
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      cyc++;
      if (done || err) break;
    end
    check("busy_start_latency", cyc, 18);
    check("busy_start_found", found, 255);
    check("busy_start_probes", probes, 9);

    // Start held during the edge where Done rises is not accepted.
    a_val = 8'd127;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("same_edge_done", done, 1);
    check("same_edge_busy", busy, 0);
    @(posedge clk); #1;
    check("same_edge_hold_done", done, 1);
    check("same_edge_hold_busy", busy, 0);

    // Comparator reports nothing: error on first sample, guess held.
    force_en = 1'b1; r_force = 3'b000;
    run(8'd50, cyc);
    check("r000_latency", cyc, 2);
    check("r000_err", err, 1);
    check("r000_done", done, 0);
    check("r000_busy", busy, 0);
    check("r000_guess", guess, 127);
    check("r000_probes", probes, 1);
    @(posedge clk); #1;
    check("r000_guess_hold", guess, 127);

    // Comparator always says A>B: error after the 255 probe without wrapping.
    r_force = 3'b100;
    run(8'd50, cyc);
    check("r100_latency", cyc, 18);
    check("r100_err", err, 1);
    check("r100_done", done, 0);
    check("r100_guess", guess, 255);
    check("r100_probes", probes, 9);
    force_en = 1'b0;

    // Combinational comparator: one edge per probe.
    a_val = 8'd200;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    check("lat0_accept_guess", guess0, 127);
    check("lat0_accept_busy", busy0, 1);
    cyc = 0;
    while (cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (done0 || err0) break;
    end
    check("lat0_latency", cyc, 8);
    check("lat0_done", done0, 1);
    check("lat0_found", found0, 200);
    check("lat0_probes", probes0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
